// File: rtl/sa_result_drain.sv
// Result-tile drain: waits for all PE results, snapshots the MxN FP32 tile,
// computes a per-row FP32 maximum, then streams one row per valid/ready beat.
module sa_result_drain #(
   parameter int M = 8,
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tile_done,
   input  logic [M*N*32-1:0] c_out_flat,
   input  logic [M*N-1:0]    c_valid_flat,
   output logic              drain_busy,
   output logic              drain_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*32-1:0]   out_row_flat,
   output logic [31:0]       out_row_max,
   output logic [15:0]       out_row_idx,
   output logic              out_last,
   output logic              err_overrun
);

   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [2:0] {IDLE, WAIT_VALID, MAX, EMIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] r;
   logic [31:0]      row_buf [M][N];
   logic [31:0]      row_max [M];
   logic [31:0]      reduce_max;
   logic             all_valid;
   logic             r_last;

   // Total order on bit patterns: positive beats negative, then magnitude
   // decides (larger for positives, smaller for negatives). NaNs are not special.
   function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31])
         return a[31] ? b : a;
      else if (!a[31])
         return (a[30:0] >= b[30:0]) ? a : b;
      else
         return (a[30:0] <= b[30:0]) ? a : b;
   endfunction

   assign all_valid = &c_valid_flat;
   assign r_last    = (r == IDX_W'(M - 1));

   // N-input reduce over the row currently addressed by r.
   always_comb begin
      reduce_max = row_buf[r][0];
      for (int j = 1; j < N; j++)
         reduce_max = fp_max(reduce_max, row_buf[r][j]);
   end

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt    = state;
      drain_busy   = 1'b0;
      drain_done   = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      out_row_flat = '0;
      out_row_max  = '0;
      out_row_idx  = '0;
      case (state)
         IDLE: begin
            if (tile_done) state_nxt = WAIT_VALID;
         end
         WAIT_VALID: begin
            drain_busy = 1'b1;
            if (all_valid) state_nxt = MAX;
         end
         MAX: begin
            drain_busy = 1'b1;
            if (r_last) state_nxt = EMIT;
         end
         EMIT: begin
            drain_busy  = 1'b1;
            out_valid   = 1'b1;
            for (int j = 0; j < N; j++)
               out_row_flat[j*32 +: 32] = row_buf[r][j];
            out_row_max = row_max[r];
            out_row_idx = 16'(r);
            out_last    = r_last;
            if (out_ready && r_last) state_nxt = DONE;
         end
         DONE: begin
            drain_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         r           <= '0;
         err_overrun <= 1'b0;
         // NOTE: the tile buffer is cleared on reset so a stale tile can never
         // leak out after an aborted drain; it is small enough to be flops.
         for (int i = 0; i < M; i++) begin
            row_max[i] <= '0;
            for (int j = 0; j < N; j++)
               row_buf[i][j] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (tile_done && state != IDLE) err_overrun <= 1'b1;
         case (state)
            WAIT_VALID: begin
               if (all_valid) begin
                  r <= '0;
                  for (int i = 0; i < M; i++)
                     for (int j = 0; j < N; j++)
                        row_buf[i][j] <= c_out_flat[(i*N+j)*32 +: 32];
               end
            end
            MAX: begin
               row_max[r] <= reduce_max;
               r          <= r_last ? '0 : r + IDX_W'(1);
            end
            EMIT: begin
               if (out_ready && !r_last) r <= r + IDX_W'(1);
            end
            DONE:    r <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain at M=N=2: latency, FP32 max ordering,
// delayed valid, backpressure, overrun and mid-tile reset.
module tb_sa_result_drain;

   localparam int M = 2;
   localparam int N = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tile_done = 1'b0;
   logic [M*N*32-1:0] c_out_flat = '0;
   logic [M*N-1:0]    c_valid_flat = '0;
   logic              out_ready = 1'b1;
   logic              drain_busy, drain_done, out_valid, out_last, err_overrun;
   logic [N*32-1:0]   out_row_flat;
   logic [31:0]       out_row_max;
   logic [15:0]       out_row_idx;

   int n_cmp = 0;
   int n_bad = 0;

   sa_result_drain #(.M(M), .N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .tile_done    (tile_done),
      .c_out_flat   (c_out_flat),
      .c_valid_flat (c_valid_flat),
      .drain_busy   (drain_busy),
      .drain_done   (drain_done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row_flat (out_row_flat),
      .out_row_max  (out_row_max),
      .out_row_idx  (out_row_idx),
      .out_last     (out_last),
      .err_overrun  (err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the cycle after the pulse was sampled.
   task automatic pulse_tile();
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   int   n;
   int   acc;
   logic seen;
   logic rdy_pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   int   exp_idx [5] = '{0, 0, 0, 1, 1};
   logic [63:0] bp_flat [2] = '{64'h00000002_00000001, 64'h00000004_00000003};
   logic [31:0] bp_max  [2] = '{32'h00000002, 32'h00000004};

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_busy",  drain_busy,   0);
      check("rst_done",  drain_done,   0);
      check("rst_valid", out_valid,    0);
      check("rst_last",  out_last,     0);
      check("rst_err",   err_overrun,  0);
      check("rst_flat",  out_row_flat, 0);
      check("rst_max",   out_row_max,  0);
      check("rst_idx",   out_row_idx,  0);
      rst = 1'b0;
      tick();

      // Basic tile: first beat at t+4, drain_done at t+6
      c_out_flat   = {32'hBF000000, 32'hBF800000, 32'hC0000000, 32'h3F800000};
      c_valid_flat = '1;
      out_ready    = 1'b1;
      pulse_tile();
      check("t1_busy", drain_busy, 1);
      wait_out(n);
      check("t1_lat",   n, 3);
      check("t1_flat0", out_row_flat, 64'hC0000000_3F800000);
      check("t1_max0",  out_row_max, 32'h3F800000);
      check("t1_idx0",  out_row_idx, 0);
      check("t1_last0", out_last, 0);
      tick();
      check("t1_flat1", out_row_flat, 64'hBF000000_BF800000);
      check("t1_max1",  out_row_max, 32'hBF000000);
      check("t1_idx1",  out_row_idx, 1);
      check("t1_last1", out_last, 1);
      tick();
      check("t1_done",      drain_done, 1);
      check("t1_busy_done", drain_busy, 0);
      check("t1_valid_done", out_valid, 0);
      tick();
      check("t1_done_pulse", drain_done, 0);

      // Signed-zero ordering
      c_out_flat = {32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000};
      pulse_tile();
      wait_out(n);
      check("t2_max0", out_row_max, 32'h00000000);
      tick();
      check("t2_max1", out_row_max, 32'h80000000);
      tick();
      tick();

      // Delayed valid, NaN/Inf ordering, capture privacy
      c_out_flat   = {4{32'h11111111}};
      c_valid_flat = 4'b0111;
      pulse_tile();
      for (int k = 0; k < 5; k++) tick();
      check("t3_hold_valid", out_valid, 0);
      check("t3_hold_busy",  drain_busy, 1);
      c_out_flat   = {32'hFF800000, 32'hFFC00000, 32'h7FC00000, 32'h7F800000};
      c_valid_flat = 4'b1111;
      wait_out(n);
      check("t3_lat", n, 3);
      c_valid_flat = '0;
      c_out_flat   = '1;
      check("t3_flat0", out_row_flat, 64'h7FC00000_7F800000);
      check("t3_max0",  out_row_max, 32'h7FC00000);
      tick();
      check("t3_flat1", out_row_flat, 64'hFF800000_FFC00000);
      check("t3_max1",  out_row_max, 32'hFF800000);
      tick();
      tick();

      // Backpressure: ready pattern 0,0,1,0,1
      c_out_flat   = {32'h4, 32'h3, 32'h2, 32'h1};
      c_valid_flat = '1;
      out_ready    = 1'b0;
      pulse_tile();
      wait_out(n);
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         out_ready = rdy_pat[k];
         check($sformatf("t4_valid%0d", k), out_valid, 1);
         check($sformatf("t4_idx%0d", k),   out_row_idx, exp_idx[k]);
         check($sformatf("t4_flat%0d", k),  out_row_flat, bp_flat[exp_idx[k]]);
         check($sformatf("t4_max%0d", k),   out_row_max, bp_max[exp_idx[k]]);
         if (out_valid && out_ready) acc++;
         tick();
      end
      check("t4_accepts", acc, 2);
      check("t4_done", drain_done, 1);
      out_ready = 1'b1;
      tick();

      // Overrun during EMIT
      pulse_tile();
      wait_out(n);
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
      check("t5_err",  err_overrun, 1);
      check("t5_idx1", out_row_idx, 1);
      tick();
      check("t5_done", drain_done, 1);
      tick();
      check("t5_idle_busy", drain_busy, 0);
      check("t5_err_sticky", err_overrun, 1);
      tick();
      tick();
      check("t5_no_rearm", drain_busy, 0);

      // Reset during MAX, then a clean capture
      pulse_tile();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy",  drain_busy,  0);
      check("t6_valid", out_valid,   0);
      check("t6_err",   err_overrun, 0);
      check("t6_max",   out_row_max, 0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (drain_done) seen = 1'b1;
         tick();
      end
      check("t6_no_done", seen, 0);
      c_out_flat = {32'h40400000, 32'h40000000, 32'hC1000000, 32'h41000000};
      pulse_tile();
      wait_out(n);
      check("t6_lat",   n, 3);
      check("t6_flat0", out_row_flat, 64'hC1000000_41000000);
      check("t6_max0",  out_row_max, 32'h41000000);
      tick();
      check("t6_max1",  out_row_max, 32'h40400000);
      tick();
      check("t6_done",  drain_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
